// File: rtl/rcpu_irq_ctrl_pkg.sv
// Shared constants for the rcpu interrupt controller.
// Register indices, FSM state encodings and a width helper.
package rcpu_irq_ctrl_pkg;

    localparam logic [2:0] IRQ_REG_CTRL   = 3'd0;
    localparam logic [2:0] IRQ_REG_MASK   = 3'd1;
    localparam logic [2:0] IRQ_REG_EDGE   = 3'd2;
    localparam logic [2:0] IRQ_REG_PEND   = 3'd3;
    localparam logic [2:0] IRQ_REG_VBLO   = 3'd4;
    localparam logic [2:0] IRQ_REG_VBHI   = 3'd5;
    localparam logic [2:0] IRQ_REG_ACTIVE = 3'd6;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_GAP  = 2'd2
    } irqState_t;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rcpu_prio_enc.sv
// Lowest-index-wins priority encoder.
// valid is high when any request bit is set.
module rcpu_prio_enc #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rcpu_irq_ctrl.sv
// Multi-channel interrupt controller feeding the rcpu core.
// Masked edge/level channels, fixed priority, hold until acknowledged.
module rcpu_irq_ctrl
    import rcpu_irq_ctrl_pkg::*;
#(
    parameter int          M            = 16,
    parameter int          N            = 32,
    parameter int          CH           = 8,
    parameter int          VSTRIDE_LOG2 = 2,
    parameter logic [N-1:0] VBASE_RST   = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] irqIn,
    input  logic [2:0]    cfgAddr,
    input  logic          cfgWE,
    input  logic [M-1:0]  cfgWData,
    output logic [M-1:0]  cfgRData,
    output logic          irq,
    input  logic          turnOffIRQ,
    output logic [N-1:0]  intAddr,
    output logic [M-1:0]  intData
);

    localparam int GW = idxWidth(CH);

    logic          ctrlEn;
    logic [CH-1:0] maskReg;
    logic [CH-1:0] edgeReg;
    logic [CH-1:0] pendEdge;
    logic [CH-1:0] irqPrev;
    logic [N-1:0]  vbase;
    logic [N-1:0]  addrHold;
    logic [M-1:0]  dataHold;
    logic [GW-1:0] gnt;
    logic [GW-1:0] gntNext;
    irqState_t     state;
    irqState_t     stateNext;

    logic [CH-1:0] pending;
    logic [CH-1:0] eligible;
    logic [CH-1:0] rise;
    logic [CH-1:0] ackClr;
    logic [CH-1:0] w1cClr;
    logic [GW-1:0] winIdx;
    logic          winValid;
    logic          ack;

    assign rise     = irqIn & ~irqPrev;
    assign pending  = (edgeReg & pendEdge) | (~edgeReg & irqIn);
    assign eligible = pending & maskReg & {CH{ctrlEn}};
    assign ack      = (state == IRQ_REQ) && turnOffIRQ;
    assign ackClr   = ack ? ((CH'(1) << gnt) & edgeReg) : '0;
    assign w1cClr   = (cfgWE && cfgAddr == IRQ_REG_PEND)
                    ? (cfgWData[CH-1:0] & edgeReg) : '0;

    rcpu_prio_enc #(
        .W  (CH),
        .IW (GW)
    ) uPrio (
        .req   (eligible),
        .idx   (winIdx),
        .valid (winValid)
    );

    // Config registers, edge detector and latched edge pending bits
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlEn   <= 1'b0;
            maskReg  <= '0;
            edgeReg  <= '0;
            pendEdge <= '0;
            irqPrev  <= '0;
            vbase    <= VBASE_RST;
        end else begin
            irqPrev  <= irqIn;
            pendEdge <= (pendEdge & ~(ackClr | w1cClr)) | (rise & edgeReg);
            if (cfgWE) begin
                case (cfgAddr)
                    IRQ_REG_CTRL: ctrlEn         <= cfgWData[0];
                    IRQ_REG_MASK: maskReg        <= cfgWData[CH-1:0];
                    IRQ_REG_EDGE: edgeReg        <= cfgWData[CH-1:0];
                    IRQ_REG_VBLO: vbase[M-1:0]   <= cfgWData;
                    IRQ_REG_VBHI: vbase[N-1:M]   <= cfgWData[N-M-1:0];
                    default: ;
                endcase
            end
        end
    end

    // FSM state, frozen grant and last presented vector
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IRQ_IDLE;
            gnt      <= '0;
            addrHold <= VBASE_RST;
            dataHold <= '0;
        end else begin
            state    <= stateNext;
            gnt      <= gntNext;
            addrHold <= intAddr;
            dataHold <= intData;
        end
    end

    // Next state: grant in IDLE, ack beats withdraw in REQ, one-cycle GAP
    always_comb begin
        stateNext = state;
        gntNext   = gnt;
        case (state)
            IRQ_IDLE: begin
                if (winValid) begin
                    gntNext   = winIdx;
                    stateNext = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (turnOffIRQ) begin
                    stateNext = IRQ_GAP;
                end else if (!eligible[gnt]) begin
                    stateNext = IRQ_IDLE;
                end
            end
            IRQ_GAP:  stateNext = IRQ_IDLE;
            default:  stateNext = IRQ_IDLE;
        endcase
    end

    assign irq     = (state == IRQ_REQ);
    assign intAddr = irq ? vbase + (N'(gnt) << VSTRIDE_LOG2) : addrHold;
    assign intData = irq ? M'(gnt) : dataHold;

    // Register read mux; unused upper bits read as zero
    always_comb begin
        cfgRData = '0;
        case (cfgAddr)
            IRQ_REG_CTRL:   cfgRData[0]        = ctrlEn;
            IRQ_REG_MASK:   cfgRData[CH-1:0]   = maskReg;
            IRQ_REG_EDGE:   cfgRData[CH-1:0]   = edgeReg;
            IRQ_REG_PEND:   cfgRData[CH-1:0]   = pending;
            IRQ_REG_VBLO:   cfgRData           = vbase[M-1:0];
            IRQ_REG_VBHI:   cfgRData[N-M-1:0]  = vbase[N-1:M];
            IRQ_REG_ACTIVE: cfgRData[GW:0]     = {irq, gnt};
            default:        cfgRData           = '0;
        endcase
    end

endmodule

// File: tb/tb_rcpu_irq_ctrl.sv
// Self-checking bench for rcpu_irq_ctrl.
// Directed scenarios plus randomized traffic against a cycle model.
module tb_rcpu_irq_ctrl;

    localparam int          M  = 16;
    localparam int          N  = 32;
    localparam int          CH = 8;
    localparam logic [31:0] VR = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irqIn;
    logic [2:0]  cfgAddr;
    logic        cfgWE;
    logic [15:0] cfgWData;
    logic [15:0] cfgRData;
    logic        irq;
    logic        turnOffIRQ;
    logic [31:0] intAddr;
    logic [15:0] intData;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    rcpu_irq_ctrl #(
        .M            (M),
        .N            (N),
        .CH           (CH),
        .VSTRIDE_LOG2 (2),
        .VBASE_RST    (VR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irqIn      (irqIn),
        .cfgAddr    (cfgAddr),
        .cfgWE      (cfgWE),
        .cfgWData   (cfgWData),
        .cfgRData   (cfgRData),
        .irq        (irq),
        .turnOffIRQ (turnOffIRQ),
        .intAddr    (intAddr),
        .intData    (intData)
    );

    // Reference model: what software and the core should observe
    bit        mEn;
    bit [7:0]  mMask, mEdge, mLatched, mLastIn;
    bit [31:0] mVbase, mAddrHold;
    bit [15:0] mDataHold;
    bit        mServing, mCooldown;
    int        mChan;

    function automatic bit [7:0] mPending();
        bit [7:0] p;
        for (int i = 0; i < CH; i++)
            p[i] = mEdge[i] ? mLatched[i] : irqIn[i];
        return p;
    endfunction

    function automatic bit mWants(int c);
        bit [7:0] p;
        p = mPending();
        return p[c] && mMask[c] && mEn;
    endfunction

    function automatic bit [31:0] mAddr();
        return mServing ? mVbase + 32'(mChan * 4) : mAddrHold;
    endfunction

    function automatic bit [15:0] mData();
        return mServing ? 16'(mChan) : mDataHold;
    endfunction

    function automatic bit [15:0] mRead(input logic [2:0] a);
        case (a)
            3'd0: return {15'd0, mEn};
            3'd1: return {8'd0, mMask};
            3'd2: return {8'd0, mEdge};
            3'd3: return {8'd0, mPending()};
            3'd4: return mVbase[15:0];
            3'd5: return mVbase[31:16];
            3'd6: return 16'(mChan) | (mServing ? 16'h0008 : 16'h0000);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic tick();
        bit [7:0] nLat;
        bit       ackNow, nServ, nCool, setB, clrB;
        int       nChan;
        if (rst) begin
            mEn = 0; mMask = 0; mEdge = 0; mLatched = 0; mLastIn = 0;
            mVbase = VR; mAddrHold = VR; mDataHold = 0;
            mServing = 0; mCooldown = 0; mChan = 0;
        end else begin
            ackNow = mServing && turnOffIRQ;
            nServ = mServing; nCool = mCooldown; nChan = mChan;
            if (mServing) begin
                if (ackNow) begin nServ = 0; nCool = 1; end
                else if (!mWants(mChan)) nServ = 0;
            end else if (mCooldown) begin
                nCool = 0;
            end else begin
                for (int i = CH - 1; i >= 0; i--)
                    if (mWants(i)) begin nServ = 1; nChan = i; end
            end
            for (int i = 0; i < CH; i++) begin
                setB = mEdge[i] && irqIn[i] && !mLastIn[i];
                clrB = mEdge[i] && ((ackNow && i == mChan) ||
                       (cfgWE && cfgAddr == 3'd3 && cfgWData[i]));
                nLat[i] = setB || (mLatched[i] && !clrB);
            end
            mAddrHold = mAddr();
            mDataHold = mData();
            mServing = nServ; mCooldown = nCool; mChan = nChan;
            mLatched = nLat; mLastIn = irqIn;
            if (cfgWE) begin
                case (cfgAddr)
                    3'd0: mEn = cfgWData[0];
                    3'd1: mMask = cfgWData[7:0];
                    3'd2: mEdge = cfgWData[7:0];
                    3'd4: mVbase[15:0] = cfgWData;
                    3'd5: mVbase[31:16] = cfgWData;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [2:0] a, input logic [15:0] d);
        cfgAddr = a; cfgWData = d; cfgWE = 1'b1;
        tick();
        cfgWE = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] want [8];
        want = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0};
        rst = 1; irqIn = 0; cfgAddr = 0; cfgWE = 0; cfgWData = 0; turnOffIRQ = 0;
        tick(); tick();
        rst = 0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b want=0", irq); end
        checks++; if (intAddr !== 32'h100) begin errors++; $display("FAIL rst_addr got=%h want=100", intAddr); end
        checks++; if (intData !== 16'h0) begin errors++; $display("FAIL rst_data got=%h want=0", intData); end
        for (int r = 0; r < 8; r++) begin
            cfgAddr = 3'(r); #1;
            checks++;
            if (cfgRData !== want[r]) begin
                errors++; $display("FAIL rst_reg%0d got=%h want=%h", r, cfgRData, want[r]);
            end
        end
    endtask

    task automatic test_edge_basic();
        cfgWrite(3'd2, 16'h05);
        cfgWrite(3'd1, 16'h05);
        cfgWrite(3'd0, 16'h01);
        irqIn = 8'h04; tick(); irqIn = 0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL eb_irq_t1 got=%b want=0", irq); end
        cfgAddr = 3'd3; #1;
        checks++; if (cfgRData !== 16'h04) begin errors++; $display("FAIL eb_pend got=%h want=0004", cfgRData); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL eb_irq_t2 got=%b want=1", irq); end
        checks++; if (intAddr !== 32'h108) begin errors++; $display("FAIL eb_addr got=%h want=00000108", intAddr); end
        checks++; if (intData !== 16'd2) begin errors++; $display("FAIL eb_data got=%h want=2", intData); end
        cfgAddr = 3'd6; #1;
        checks++; if (cfgRData !== 16'h000A) begin errors++; $display("FAIL eb_active got=%h want=000a", cfgRData); end
        turnOffIRQ = 1; tick(); turnOffIRQ = 0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL eb_gap got=%b want=0", irq); end
        cfgAddr = 3'd3; #1;
        checks++; if (cfgRData !== 16'h0) begin errors++; $display("FAIL eb_pendclr got=%h want=0", cfgRData); end
        checks++; if (intAddr !== 32'h108) begin errors++; $display("FAIL eb_hold got=%h want=00000108", intAddr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL eb_idle%0d got=%b want=0", k, irq); end
        end
    endtask

    task automatic test_priority();
        cfgWrite(3'd2, 16'h0D);
        cfgWrite(3'd1, 16'h0F);
        irqIn = 8'h09; tick(); irqIn = 0; tick();
        checks++; if (irq !== 1'b1 || intData !== 16'd0) begin
            errors++; $display("FAIL pr_first got irq=%b ch=%0d want irq=1 ch=0", irq, intData); end
        checks++; if (intAddr !== 32'h100) begin errors++; $display("FAIL pr_addr0 got=%h want=00000100", intAddr); end
        turnOffIRQ = 1; tick(); turnOffIRQ = 0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pr_gap got=%b want=0", irq); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pr_idle got=%b want=0", irq); end
        tick();
        checks++; if (irq !== 1'b1 || intData !== 16'd3) begin
            errors++; $display("FAIL pr_second got irq=%b ch=%0d want irq=1 ch=3", irq, intData); end
        checks++; if (intAddr !== 32'h10C) begin errors++; $display("FAIL pr_addr3 got=%h want=0000010c", intAddr); end
        turnOffIRQ = 1; tick(); turnOffIRQ = 0; tick();
    endtask

    task automatic test_level_withdraw();
        irqIn = 8'h02; tick();
        checks++; if (irq !== 1'b1 || intAddr !== 32'h104) begin
            errors++; $display("FAIL lv_req got irq=%b addr=%h want irq=1 addr=00000104", irq, intAddr); end
        irqIn = 0; tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lv_withdraw got=%b want=0", irq); end
        cfgAddr = 3'd6; #1;
        checks++; if (cfgRData[3] !== 1'b0) begin errors++; $display("FAIL lv_valid got=%b want=0", cfgRData[3]); end
        cfgAddr = 3'd3; #1;
        checks++; if (cfgRData[1] !== 1'b0) begin errors++; $display("FAIL lv_pend got=%b want=0", cfgRData[1]); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lv_stay got=%b want=0", irq); end
    endtask

    task automatic test_back_to_back();
        irqIn = 8'h04; tick(); irqIn = 0; tick();
        checks++; if (irq !== 1'b1 || intData !== 16'd2) begin
            errors++; $display("FAIL bb_req1 got irq=%b ch=%0d want irq=1 ch=2", irq, intData); end
        turnOffIRQ = 1; irqIn = 8'h04; tick(); turnOffIRQ = 0; irqIn = 0;
        cfgAddr = 3'd3; #1;
        checks++; if (cfgRData[2] !== 1'b1) begin errors++; $display("FAIL bb_setwins got=%b want=1", cfgRData[2]); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL bb_gap got=%b want=0", irq); end
        tick(); tick();
        checks++; if (irq !== 1'b1 || intData !== 16'd2) begin
            errors++; $display("FAIL bb_req2 got irq=%b ch=%0d want irq=1 ch=2", irq, intData); end
        turnOffIRQ = 1; tick(); turnOffIRQ = 0; tick(); tick();
    endtask

    task automatic test_wrap_w1c();
        cfgWrite(3'd2, 16'h0F);
        cfgWrite(3'd4, 16'hFFFC);
        cfgWrite(3'd5, 16'hFFFF);
        irqIn = 8'h02; tick(); irqIn = 0; tick();
        checks++; if (irq !== 1'b1 || intAddr !== 32'h0) begin
            errors++; $display("FAIL wr_addr got irq=%b addr=%h want irq=1 addr=00000000", irq, intAddr); end
        cfgWrite(3'd3, 16'h02);
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wr_w1c got=%b want=0", irq); end
        cfgAddr = 3'd6; #1;
        checks++; if (cfgRData[3] !== 1'b0) begin errors++; $display("FAIL wr_valid got=%b want=0", cfgRData[3]); end
        cfgWrite(3'd4, 16'h0100);
        cfgWrite(3'd5, 16'h0000);
    endtask

    task automatic test_reset_mid();
        logic [15:0] want [8];
        want = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0};
        irqIn = 8'h01; tick(); irqIn = 0; tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rm_req got=%b want=1", irq); end
        rst = 1; tick(); rst = 0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rm_irq got=%b want=0", irq); end
        checks++; if (intAddr !== 32'h100 || intData !== 16'h0) begin
            errors++; $display("FAIL rm_vec got addr=%h data=%h want 00000100/0", intAddr, intData); end
        for (int r = 0; r < 8; r++) begin
            cfgAddr = 3'(r); #1;
            checks++;
            if (cfgRData !== want[r]) begin
                errors++; $display("FAIL rm_reg%0d got=%h want=%h", r, cfgRData, want[r]);
            end
        end
    endtask

    task automatic test_idle_ack();
        cfgWrite(3'd2, 16'h01);
        cfgWrite(3'd0, 16'h01);
        irqIn = 8'h01; tick(); irqIn = 0;
        turnOffIRQ = 1; tick(); turnOffIRQ = 0;
        cfgAddr = 3'd3; #1;
        checks++; if (cfgRData !== 16'h01) begin errors++; $display("FAIL ia_pend got=%h want=0001", cfgRData); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ia_irq got=%b want=0", irq); end
        cfgWrite(3'd3, 16'h01);
        cfgAddr = 3'd3; #1;
        checks++; if (cfgRData !== 16'h0) begin errors++; $display("FAIL ia_w1c got=%h want=0", cfgRData); end
    endtask

    task automatic test_random();
        logic [7:0] flip;
        cfgWrite(3'd1, 16'($urandom_range(0, 255)));
        cfgWrite(3'd2, 16'($urandom_range(0, 255)));
        cfgWrite(3'd0, 16'h01);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            flip = 0;
            for (int i = 0; i < CH; i++) flip[i] = ($urandom_range(0, 7) == 0);
            irqIn      = irqIn ^ flip;
            turnOffIRQ = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 599) == 0);
            cfgWE      = ($urandom_range(0, 15) == 0);
            cfgAddr    = 3'($urandom_range(0, 7));
            cfgWData   = 16'($urandom);
            if (cfgWE && cfgAddr == 3'd0) cfgWData[0] = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (irq !== mServing) begin
                errors++; $display("FAIL rnd_irq cyc=%0d got=%b want=%b", cyc, irq, mServing); end
            checks++; if (intAddr !== mAddr()) begin
                errors++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, intAddr, mAddr()); end
            checks++; if (intData !== mData()) begin
                errors++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, intData, mData()); end
            checks++; if (cfgRData !== mRead(cfgAddr)) begin
                errors++; $display("FAIL rnd_reg%0d cyc=%0d got=%h want=%h", cfgAddr, cyc, cfgRData, mRead(cfgAddr)); end
            tick();
        end
        cfgWE = 0; rst = 0; turnOffIRQ = 0; irqIn = 0;
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_priority();
        test_level_withdraw();
        test_back_to_back();
        test_wrap_w1c();
        test_reset_mid();
        test_idle_ack();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
